// File: rtl/matrix_pkg.sv
// Shared definitions for the 74HC595 RGB matrix chain: field layout,
// colour naming and decode helpers.
package matrix_pkg;
  localparam int CHAIN_BITS = 32;
  localparam int ANODE_LSB  = 0;
  localparam int GREEN_LSB  = 8;
  localparam int BLUE_LSB   = 16;
  localparam int RED_LSB    = 24;

  typedef enum logic [1:0] {RED, BLUE, GREEN} colour_e;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] anode;
  } frame_t;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) if (v[i]) idx = idx | 3'(i);
    return idx;
  endfunction

  // Column 0 is shifted first so it ends up in the field MSB; wire is active-low.
  function automatic logic [7:0] colour_lit(input logic [CHAIN_BITS-1:0] sr, input colour_e c);
    logic [7:0] raw;
    case (c)
      RED:     raw = sr[RED_LSB +: 8];
      BLUE:    raw = sr[BLUE_LSB +: 8];
      default: raw = sr[GREEN_LSB +: 8];
    endcase
    return ~rev8(raw);
  endfunction
endpackage

// File: rtl/matrix_rx_if.sv
// Chain pins, control and decoded results of the matrix receiver.
interface matrix_rx_if;
  logic       matrix_clk, matrix_latch, matrix_mosi, err_clr;
  logic [2:0] rd_row, row_idx;
  logic [7:0] rd_red, rd_green, rd_blue;
  logic [7:0] lat_red, lat_blue, lat_green, lat_anode;
  logic [5:0] lat_bits;
  logic       latch_stb, frame_err;

  modport slave (
    input  matrix_clk, matrix_latch, matrix_mosi, err_clr, rd_row,
    output rd_red, rd_green, rd_blue, latch_stb, lat_red, lat_blue,
           lat_green, lat_anode, lat_bits, row_idx, frame_err
  );
  modport master (
    output matrix_clk, matrix_latch, matrix_mosi, err_clr, rd_row,
    input  rd_red, rd_green, rd_blue, latch_stb, lat_red, lat_blue,
           lat_green, lat_anode, lat_bits, row_idx, frame_err
  );
endinterface

// File: rtl/sync_rise.sv
// Multi-stage synchroniser with an armed rising-edge detector.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d, fill_q, fill_d;
  logic              prev_q, prev_d, arm_q, arm_d;

  assign lvl  = sync_q[STAGES-1];
  assign rise = lvl & ~prev_q & arm_q;

  // The reset zeros in the chain are not a real low; arm only once the
  // chain holds genuine samples so a pin held high through reset is ignored.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    fill_d = {fill_q[STAGES-2:0], 1'b1};
    prev_d = lvl;
    arm_d  = arm_q | (fill_q[STAGES-1] & ~lvl);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fill_q <= fill_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end
endmodule

// File: rtl/matrix_rx.sv
// Receiver/monitor for the RGB matrix 595 chain: models the shift/storage
// registers, decodes each latched frame and keeps an 8-row shadow framebuffer.
module matrix_rx
  import matrix_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  matrix_rx_if.slave bus
);
  logic                   clk_lvl_unused, lat_lvl_unused, shift, latch, mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [CHAIN_BITS-1:0]  sr_q, sr_d, cap_sr_q, cap_sr_d;
  logic [5:0]             cnt_q, cnt_d, cap_bits_q, cap_bits_d, lat_bits_q, lat_bits_d;
  logic [1:0]             vld_pipe_q, vld_pipe_d;
  frame_t                 dec, lat_q, lat_d;
  logic                   blank, good, err_q, err_d;
  logic [2:0]             row_q, row_d;
  logic [7:0][23:0]       fb_q, fb_d;
  logic [23:0]            rd_q, rd_d;

  sync_rise #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(clk_25mhz), .rst(reset), .d(bus.matrix_clk), .lvl(clk_lvl_unused), .rise(shift)
  );
  sync_rise #(.STAGES(SYNC_STAGES)) u_lat_sync (
    .clk(clk_25mhz), .rst(reset), .d(bus.matrix_latch), .lvl(lat_lvl_unused), .rise(latch)
  );

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Stage 1: shift register and counter; a latch snapshots the pre-shift
  // contents, matching 595 storage-before-shift behaviour.
  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.matrix_mosi};
    sr_d        = shift ? {sr_q[CHAIN_BITS-2:0], mosi_s} : sr_q;
    cnt_d       = cnt_q;
    if (latch)                       cnt_d = shift ? 6'd1 : 6'd0;
    else if (shift && cnt_q != 6'h3f) cnt_d = cnt_q + 6'd1;
    cap_sr_d    = latch ? sr_q : cap_sr_q;
    cap_bits_d  = latch ? cnt_q : cap_bits_q;
    vld_pipe_d  = {vld_pipe_q[0], latch};
  end

  // Stage 2: decode, classify and commit the captured frame.
  always_comb begin
    dec   = {colour_lit(cap_sr_q, RED), colour_lit(cap_sr_q, BLUE),
             colour_lit(cap_sr_q, GREEN), rev8(cap_sr_q[ANODE_LSB +: 8])};
    blank = &cap_sr_q[CHAIN_BITS-1:GREEN_LSB];
    good  = !blank && cap_bits_q == 6'(CHAIN_BITS) && $onehot(dec.anode);
    lat_d      = lat_q;
    lat_bits_d = lat_bits_q;
    row_d      = row_q;
    fb_d       = fb_q;
    err_d      = err_q & ~bus.err_clr;
    if (vld_pipe_q[0]) begin
      lat_d      = dec;
      lat_bits_d = cap_bits_q;
      if (good) begin
        row_d       = onehot_idx(dec.anode);
        fb_d[row_d] = {dec.red, dec.green, dec.blue};
      end else if (!blank) begin
        err_d = 1'b1;
      end
    end
    rd_d = fb_q[bus.rd_row];
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      mosi_sync_q <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      cap_sr_q    <= '0;
      cap_bits_q  <= '0;
      vld_pipe_q  <= '0;
      lat_q       <= '0;
      lat_bits_q  <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
      fb_q        <= '0;
      rd_q        <= '0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      cap_sr_q    <= cap_sr_d;
      cap_bits_q  <= cap_bits_d;
      vld_pipe_q  <= vld_pipe_d;
      lat_q       <= lat_d;
      lat_bits_q  <= lat_bits_d;
      row_q       <= row_d;
      err_q       <= err_d;
      fb_q        <= fb_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.latch_stb = vld_pipe_q[1];
  assign bus.lat_red   = lat_q.red;
  assign bus.lat_blue  = lat_q.blue;
  assign bus.lat_green = lat_q.green;
  assign bus.lat_anode = lat_q.anode;
  assign bus.lat_bits  = lat_bits_q;
  assign bus.row_idx   = row_q;
  assign bus.frame_err = err_q;
  assign bus.rd_red    = rd_q[23:16];
  assign bus.rd_green  = rd_q[15:8];
  assign bus.rd_blue   = rd_q[7:0];
endmodule

// File: tb/tb_matrix_rx.sv
// Directed bench for matrix_rx: frame table plus hand-written corner sequences.
module tb_matrix_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  matrix_rx_if bus();
  matrix_rx #(.SYNC_STAGES(2)) dut (.clk_25mhz(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  r, b, g, a;
    int          nbits;
    logic [7:0]  e_red, e_blue, e_green, e_anode;
    logic [5:0]  e_bits;
    logic [2:0]  e_row;
    logic        e_err;
    logic [2:0]  rd_row;
    logic [23:0] e_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.matrix_mosi = b;
    bus.matrix_clk  = 1'b0;
    ticks(2);
    bus.matrix_clk  = 1'b1;
    ticks(2);
  endtask

  // Fields go out red, blue, green, anode; bit 0 of each field first.
  task automatic send_frame(input logic [7:0] r, b, g, a, input int nbits);
    logic [31:0] stream;
    stream = {a, g, b, r};
    for (int k = 0; k < nbits; k++) send_bit(stream[k]);
  endtask

  // Raise the latch pin and return the cycle count until latch_stb (-1 on timeout).
  task automatic do_latch(output int lat);
    lat = -1;
    bus.matrix_latch = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (bus.latch_stb) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_latch();
    bus.matrix_latch = 1'b0;
    ticks(2);
  endtask

  task automatic clear_err(input string name);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check(name, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.matrix_clk = 1'b0; bus.matrix_latch = 1'b0; bus.matrix_mosi = 1'b0;
    bus.err_clr = 1'b0; bus.rd_row = 3'd0;

    //              r      b      g      a    n   red    blue   green  anode  bits row err  rdrow rd
    vecs[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32, 8'h00, 8'h00, 8'h00, 8'hFF, 6'd32, 3'd0, 1'b0, 3'd0, 24'h000000};
    vecs[1] = '{8'hAA, 8'hFF, 8'hFF, 8'h04, 32, 8'h55, 8'h00, 8'h00, 8'h04, 6'd32, 3'd2, 1'b0, 3'd2, 24'h550000};
    vecs[2] = '{8'hFF, 8'hF0, 8'h0F, 8'h80, 32, 8'h00, 8'h0F, 8'hF0, 8'h80, 6'd32, 3'd7, 1'b0, 3'd7, 24'h00F00F};
    vecs[3] = '{8'hFE, 8'hFF, 8'hFF, 8'h06, 32, 8'h01, 8'h00, 8'h00, 8'h06, 6'd32, 3'd7, 1'b1, 3'd1, 24'h000000};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 32, 8'hFF, 8'hFF, 8'hFF, 8'h00, 6'd32, 3'd7, 1'b1, 3'd2, 24'h550000};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h04, 31, 8'hFF, 8'hFF, 8'hFF, 8'h08, 6'd31, 3'd7, 1'b1, 3'd3, 24'h000000};
    vecs[6] = '{8'h00, 8'hFF, 8'hFF, 8'h01, 32, 8'hFF, 8'h00, 8'h00, 8'h01, 6'd32, 3'd0, 1'b0, 3'd0, 24'hFF0000};
    vecs[7] = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 32, 8'h00, 8'h00, 8'h00, 8'h01, 6'd32, 3'd0, 1'b0, 3'd0, 24'hFF0000};

    ticks(3);
    rst = 1'b0;
    tick();
    check("rst latch_stb", 32'(bus.latch_stb), 32'd0);
    check("rst lat_frame", {bus.lat_red, bus.lat_blue, bus.lat_green, bus.lat_anode}, 32'd0);
    check("rst lat_bits",  32'(bus.lat_bits), 32'd0);
    check("rst row_idx",   32'(bus.row_idx), 32'd0);
    check("rst frame_err", 32'(bus.frame_err), 32'd0);
    for (int r = 0; r < 8; r++) begin
      bus.rd_row = 3'(r);
      tick();
      check($sformatf("rst fb row%0d", r), 32'({bus.rd_red, bus.rd_green, bus.rd_blue}), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].r, vecs[i].b, vecs[i].g, vecs[i].a, vecs[i].nbits);
      do_latch(lat);
      check($sformatf("v%0d stb_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d lat_red", i),   32'(bus.lat_red),   32'(vecs[i].e_red));
      check($sformatf("v%0d lat_blue", i),  32'(bus.lat_blue),  32'(vecs[i].e_blue));
      check($sformatf("v%0d lat_green", i), 32'(bus.lat_green), 32'(vecs[i].e_green));
      check($sformatf("v%0d lat_anode", i), 32'(bus.lat_anode), 32'(vecs[i].e_anode));
      check($sformatf("v%0d lat_bits", i),  32'(bus.lat_bits),  32'(vecs[i].e_bits));
      check($sformatf("v%0d row_idx", i),   32'(bus.row_idx),   32'(vecs[i].e_row));
      check($sformatf("v%0d frame_err", i), 32'(bus.frame_err), 32'(vecs[i].e_err));
      bus.rd_row = vecs[i].rd_row;
      tick();
      check($sformatf("v%0d stb_one_cycle", i), 32'(bus.latch_stb), 32'd0);
      check($sformatf("v%0d fb_read", i), 32'({bus.rd_red, bus.rd_green, bus.rd_blue}), 32'(vecs[i].e_rd));
      release_latch();
      if (vecs[i].e_err) clear_err($sformatf("v%0d err_clr", i));
    end

    // Shift and latch rising together after a full frame.
    send_frame(8'hFD, 8'hFF, 8'hFF, 8'h08, 32);
    bus.matrix_mosi = 1'b1;
    bus.matrix_clk  = 1'b0;
    ticks(2);
    bus.matrix_clk  = 1'b1;
    do_latch(lat);
    check("sim stb_latency", 32'(lat), 32'd4);
    check("sim lat_bits",  32'(bus.lat_bits), 32'd32);
    check("sim lat_red",   32'(bus.lat_red), 32'h02);
    check("sim row_idx",   32'(bus.row_idx), 32'd3);
    check("sim frame_err", 32'(bus.frame_err), 32'd0);
    bus.rd_row = 3'd3;
    tick();
    check("sim fb row3", 32'({bus.rd_red, bus.rd_green, bus.rd_blue}), 32'h020000);
    release_latch();
    do_latch(lat);
    check("sim next lat_bits", 32'(bus.lat_bits), 32'd1);
    check("sim next frame_err", 32'(bus.frame_err), 32'd1);
    release_latch();
    clear_err("sim err_clr");

    // Counter saturation, with err_clr held across the error strobe.
    bus.err_clr = 1'b1;
    for (int k = 0; k < 70; k++) send_bit(1'b0);
    do_latch(lat);
    check("sat lat_bits", 32'(bus.lat_bits), 32'd63);
    check("sat err_wins", 32'(bus.frame_err), 32'd1);
    tick();
    check("sat err_cleared", 32'(bus.frame_err), 32'd0);
    bus.err_clr = 1'b0;
    release_latch();

    // matrix_clk held high through reset must not shift.
    bus.matrix_clk  = 1'b1;
    bus.matrix_mosi = 1'b1;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(6);
    bus.rd_row = 3'd0;
    tick();
    check("rst2 fb row0", 32'({bus.rd_red, bus.rd_green, bus.rd_blue}), 32'd0);
    check("rst2 row_idx", 32'(bus.row_idx), 32'd0);
    do_latch(lat);
    check("hold stb_latency", 32'(lat), 32'd4);
    check("hold lat_bits",  32'(bus.lat_bits), 32'd0);
    check("hold lat_anode", 32'(bus.lat_anode), 32'd0);
    check("hold lat_red",   32'(bus.lat_red), 32'hFF);
    release_latch();
    clear_err("hold err_clr");
    send_bit(1'b1);
    do_latch(lat);
    check("first lat_bits",  32'(bus.lat_bits), 32'd1);
    check("first lat_anode", 32'(bus.lat_anode), 32'h80);
    release_latch();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_rx.md
# matrix_rx

Serial receiver and monitor for the 8x8 RGB LED matrix 74HC595 chain. It samples the three chain wires (shift clock, latch, data) in the system clock domain and models the 32-bit shift/storage register pair. Each latched frame is decoded into per-colour column bytes and a row index, and stored into an 8-row shadow framebuffer. The block sits on the far end of the matrix driver's output pins, as an on-chip checker or loopback monitor.

## Interface
- SYNC_STAGES, 2, synchroniser depth on matrix_clk/matrix_latch/matrix_mosi (≥2)
- clk_25mhz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- matrix_clk  in  1  chain shift clock; rising edge shifts
- matrix_latch  in  1  chain storage clock (CE); rising edge latches
- matrix_mosi  in  1  chain serial data
- err_clr  in  1  clears frame_err
- rd_row  in  3  framebuffer read address
- rd_red, rd_green, rd_blue  out  8 each  framebuffer row contents, active-high
- latch_stb  out  1  one-cycle pulse per captured latch
- lat_red, lat_blue, lat_green, lat_anode  out  8 each  last latched frame, decoded
- lat_bits  out  6  shifts since previous latch, saturating at 63
- row_idx  out  3  row of last good frame
- frame_err  out  1  sticky malformed-frame flag

## Operation
- Shift register sr[31:0]: on each detected matrix_clk rise, sr <= {sr[30:0], synced mosi}.
- Field order on the wire is red, blue, green, anode, each 8 bits, column 0 first. After 32 shifts: red col i = sr[31-i], blue col i = sr[23-i], green col i = sr[15-i], anode row i = sr[7-i].
- Colour bits are active-low on the wire. lat_red/blue/green are inverted, so 1 = lit. Anode is active-high and passes through uninverted.
- Shift counter: increments per shift, saturates at 63.
- On a matrix_latch rise:
  - capture decoded sr into lat_* and the counter into lat_bits;
  - counter <= 0;
  - pulse latch_stb.
- Frame classification on each latch:
  - blank: all 24 raw colour bits = 1. No error, no write. This covers the driver's reset frame of 32 ones.
  - good: lat_bits == 32, anode one-hot, not blank. row_idx <= index of the set anode bit; fb[row_idx] <= {red, green, blue}.
  - otherwise: frame_err <= 1, no write.
- frame_err is sticky. err_clr clears it. If err_clr and a new error occur in the same cycle, the error wins.
- Framebuffer: 8 × 24 bits. Read port is registered with 1-cycle latency. A read of the row being written returns the old data.
- Simultaneous shift and latch rise in one sample: the latch captures the pre-shift sr, the shift still happens, and the counter becomes 1. This matches 74HC595 storage-before-shift semantics.

## Timing
- Synchroniser latency is SYNC_STAGES cycles, plus 1 cycle for edge detect.
  - sr updates SYNC_STAGES+1 cycles after a pin rise.
  - latch_stb, lat_* and row_idx update SYNC_STAGES+2 cycles after a latch pin rise. fb and frame_err update in the same cycle.
- Input high and low times must each be ≥2 clk_25mhz cycles. The driver's fastest setting (4-cycle period) meets this. Narrower pulses may be missed.
- mosi is sampled through the same synchroniser depth as matrix_clk. It must be stable ≥1 cycle before and after the clock rise.
- Reset clears all state:
  - outputs: all 0;
  - sr, counter, fb: 0;
  - synchroniser flops: 0.
- Edge arming: each edge detector is disarmed at reset and arms only after its synced input is seen low. A pin held high through reset release therefore produces no spurious edge.
- Reset mid-frame discards the partial frame. The next latch reports the shift count since reset.

## Structure
- matrix_pkg holds:
  - CHAIN_BITS = 32;
  - field offsets RED_LSB/BLUE_LSB/GREEN_LSB/ANODE_LSB;
  - colour enum {RED, BLUE, GREEN} shared with the driver.
- One sub-module, sync_rise: SYNC_STAGES synchroniser, arm flag and rising-edge pulse, with the synced level also output. Instantiated once each for matrix_clk and matrix_latch. mosi uses a bare synchroniser of equal depth.

## Test plan
- Reset, then drive the 32-ones frame and latch → latch_stb once, lat_bits = 32, all lat colours 0, lat_anode = FF, frame_err = 0, fb unchanged.
- Red = raw 8'b10101010 (col0 first), blue/green raw FF, anode 8'b00000100 → lat_red = 55, row_idx = 2, rd_row = 2 gives rd_red = 55 one cycle later.
- Send 31 bits then latch → lat_bits = 31, frame_err = 1, no fb write. Pulse err_clr → frame_err = 0.
- Send anode = 8'b00000110 with red lit → frame_err = 1, row_idx unchanged.
- Shift and latch rise in the same cycle after 32 bits → latch captures the 32-bit frame and the next lat_bits count starts at 1.
- Hold matrix_clk high across reset deassert → no shift; sr stays 0 until the first low-to-high transition.
